pkt_maker_tx: RTL

Transmit sequencer for the packet maker. On each trigger it walks the packet-maker header register block word by word through `header_word_number` and forwards the returned `header_data`/`header_ctrl` onto the user datapath. It then appends `NUM_WORDS_PAYLOAD` generated payload words and pulses `evt_pkt_sent` back to the header block so the sent-packet counter advances. The block sits between the header/register block and the output queues.

---
 rtl/pkt_maker_tx.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pkt_maker_tx.sv
// Transmit sequencer: streams header words from the header block, then generated payload words.
// Optional auto-trigger timer is built when PKT_MAKER_TIMER_EN is defined.
module pkt_maker_tx #(
  parameter int unsigned DATA_WIDTH         = 64,
  parameter int unsigned CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter int unsigned HEADER_LENGTH      = 7,
  parameter int unsigned HEADER_LENGTH_SIZE = 3,
  parameter int unsigned NUM_WORDS_PAYLOAD  = 8,
  parameter int unsigned PERIOD_CYCLES      = 125000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          tx_trigger,
  output logic [HEADER_LENGTH_SIZE-1:0] header_word_number,
  input  logic [DATA_WIDTH-1:0]         header_data,
  input  logic [CTRL_WIDTH-1:0]         header_ctrl,
  output logic                          evt_pkt_sent,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [CTRL_WIDTH-1:0]         out_ctrl,
  output logic                          out_wr,
  input  logic                          out_rdy,
  output logic                          trig_dropped
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HEADER_LENGTH - 1);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(NUM_WORDS_PAYLOAD - 1);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        word_cnt, word_cnt_n;
  logic [31:0]             seq_num, seq_num_n;
  logic                    pending, pending_n;
  logic                    out_wr_n, evt_n, drop_n;
  logic [DATA_WIDTH-1:0]   out_data_n;
  logic [CTRL_WIDTH-1:0]   out_ctrl_n;
  logic                    trig;

`ifdef PKT_MAKER_TIMER_EN
  // Free-running period counter; held at reload while generation is disabled
  logic [31:0] timer;
  logic        tick;

  assign tick = enable && (timer == 32'd0);

  always_ff @(posedge clk) begin
    if (reset || !enable || (timer == 32'd0))
      timer <= 32'(PERIOD_CYCLES - 1);
    else
      timer <= timer - 32'd1;
  end

  assign trig = tx_trigger | tick;
`else
  logic [31:0] unused_period;
  assign unused_period = 32'(PERIOD_CYCLES);
  assign trig = tx_trigger;
`endif

  assign header_word_number = (state == HDR) ? HEADER_LENGTH_SIZE'(word_cnt) : '0;

  // Next-state and next-output decode
  always_comb begin
    state_n    = state;
    word_cnt_n = word_cnt;
    seq_num_n  = seq_num;
    pending_n  = pending;
    out_wr_n   = 1'b0;
    out_data_n = out_data;
    out_ctrl_n = out_ctrl;
    evt_n      = 1'b0;
    drop_n     = trig && (pending || !enable);

    if (trig && !pending && enable)
      pending_n = 1'b1;

    case (state)
      IDLE: begin
        if (pending && enable) begin
          pending_n  = 1'b0;
          word_cnt_n = '0;
          state_n    = HDR;
        end
      end
      HDR: begin
        if (out_rdy) begin
          out_wr_n   = 1'b1;
          out_data_n = header_data;
          out_ctrl_n = header_ctrl;
          if (word_cnt == HDR_LAST) begin
            word_cnt_n = '0;
            state_n    = PAYLOAD;
          end else begin
            word_cnt_n = word_cnt + CNT_W'(1);
          end
        end
      end
      PAYLOAD: begin
        if (out_rdy) begin
          out_wr_n   = 1'b1;
          out_data_n = DATA_WIDTH'({seq_num, 16'h0000, word_cnt});
          out_ctrl_n = (word_cnt == PAY_LAST) ? CTRL_WIDTH'(1) : '0;
          if (word_cnt == PAY_LAST) begin
            evt_n      = 1'b1;
            seq_num_n  = seq_num + 32'd1;
            word_cnt_n = '0;
            state_n    = IDLE;
          end else begin
            word_cnt_n = word_cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      word_cnt     <= '0;
      seq_num      <= '0;
      pending      <= 1'b0;
      out_wr       <= 1'b0;
      out_data     <= '0;
      out_ctrl     <= '0;
      evt_pkt_sent <= 1'b0;
      trig_dropped <= 1'b0;
    end else begin
      state        <= state_n;
      word_cnt     <= word_cnt_n;
      seq_num      <= seq_num_n;
      pending      <= pending_n;
      out_wr       <= out_wr_n;
      out_data     <= out_data_n;
      out_ctrl     <= out_ctrl_n;
      evt_pkt_sent <= evt_n;
      trig_dropped <= drop_n;
    end
  end

endmodule
